icache_refill_unit: RTL and testbench
=====================================

# icache_refill_unit

Instruction-cache refill engine that sits directly upstream of the I-cache return buffer. On a miss it issues one line-aligned 4-beat read to the memory interface, collects the 32-bit return beats into a 128-bit line, then pulses a line-write strobe. The strobe loads the return buffer and the cache data RAMs in the same cycle. It also drives the word-select used to pick the missing instruction out of the buffered line.

## Interface
- ADDR_WIDTH, 32, byte address width
- BEATS, 4, words per line; fixed to CACHE_LINE_WIDTH/WORD (128/32)
- clk  in  1  system clock, rising edge
- rstn  in  1  reset, asynchronous assert, active-low
- miss_req  in  1  refill request from I-cache FSM; held high until refill_done
- miss_addr  in  ADDR_WIDTH  byte address of missing instruction; stable while miss_req high
- rd_req  out  1  read request to memory interface
- rd_addr  out  ADDR_WIDTH  line-aligned address (miss_addr with bits [3:0] cleared)
- rd_rdy  in  1  memory accepts request when rd_req && rd_rdy
- ret_valid  in  1  return beat valid
- ret_last  in  1  memory marks final beat
- ret_data  in  WORD  return beat data
- line_we  out  1  one-cycle write strobe to return buffer / data RAM
- line_data  out  CACHE_LINE_WIDTH  assembled line; beat k in bits [32k+31:32k]
- word_sel  out  CACHE_LINE_BYTE_LOG-2  miss_addr[3:2], captured at request
- refill_busy  out  1  high in any state except IDLE
- refill_done  out  1  one-cycle pulse, coincident with line_we
- proto_err  out  1  sticky: ret_last disagreed with beat count

## Operation
- States: IDLE, REQ, RECV, DONE.
- IDLE: miss_req sampled high → capture rd_addr and word_sel, clear beat counter, go to REQ.
- REQ: rd_req=1. rd_rdy=1 → RECV; otherwise stay. rd_addr is held constant.
- RECV: each ret_valid beat writes ret_data into line slot cnt, then cnt increments (2-bit).
  - Beat with cnt==3 completes the line and moves to DONE. ret_valid is ignored outside RECV.
  - ret_last must coincide with cnt==3. If ret_last arrives with cnt!=3, or cnt==3 arrives without ret_last, set proto_err.
  - Completion is governed by cnt only.
- DONE: line_we=1, refill_done=1 for exactly one cycle, then IDLE. line_data stays stable until the next refill writes beat 0.
- miss_req outside IDLE is ignored. A new miss is accepted no earlier than the cycle after DONE.
- Reset (any state, any time):
  - state IDLE; rd_req, line_we, refill_done, refill_busy, proto_err = 0
  - rd_addr, line_data, word_sel, cnt = 0
  - Partial line discarded.

## Timing
- miss_req high in cycle t (IDLE) → rd_req high from t+1. All outputs are registered.
- Handshake completes in cycle u (rd_req && rd_rdy) → RECV from u+1. Beats may arrive from u+1, back-to-back or with gaps.
- Fourth beat in cycle v → line_we/refill_done high in v+1 → IDLE in v+2.
- Minimum miss-to-line_we latency: 6 cycles (rd_rdy=1 at t+1, beats at t+2..t+5).
- Beat arriving in the same cycle as the request handshake is not permitted; memory guarantees this.

## Configuration
- REFILL_EARLY_FWD_EN defined: adds outputs early_valid (1) and early_inst (WORD).
  - early_valid pulses for one cycle, registered, the cycle after the beat whose index equals word_sel is received.
  - early_inst carries that beat's data.
  - Lets the fetch stage restart before line_we.
- Not defined: ports absent; the instruction is available only through the return buffer after line_we.

## Structure
- CPU_Parameter.vh holds the shared constants: WORD, CACHE_LINE_WIDTH, CACHE_LINE_BYTE_LOG, refill state encodings (REFILL_IDLE/REQ/RECV/DONE).
- One sub-module: refill_beat_collector — cnt, slot write-enable decode, line_data register, proto_err check.
- The top level holds the FSM and request registers.

## Test plan
- miss_addr=0x1C00_0034, rd_rdy=1 immediately, beats 0xA0..0xA3 back-to-back, ret_last on 4th:
  - rd_addr=0x1C00_0030, word_sel=2'b01
  - line_data=0x000000A3_000000A2_000000A1_000000A0
  - line_we one cycle at miss+6
- rd_rdy withheld 5 cycles, then beats with 2-cycle gaps → rd_req/rd_addr held stable throughout; line identical; line_we once.
- ret_last asserted on beat 2 → proto_err=1 and stays 1; line still completes on beat 4.
- rstn pulled low after beat 2 → all outputs 0 asynchronously. Next miss of 0x0000_0100 starts clean at cnt=0.
- miss_req held high across DONE → exactly one refill per request window; new refill starts the cycle after return to IDLE.
- REFILL_EARLY_FWD_EN with miss_addr low bits 0x8 → early_valid pulses after beat 2 only, early_inst = beat-2 data.

Source files
------------

// File: rtl/icache_refill_unit_pkg.sv
// Shared constants, state encodings and small types for the I-cache refill engine.
package icache_refill_unit_pkg;

  localparam int WORD                = 32;
  localparam int CACHE_LINE_WIDTH    = 128;
  localparam int CACHE_LINE_BYTE_LOG = 4;
  localparam int BEATS               = CACHE_LINE_WIDTH / WORD;
  localparam int CNT_W               = $clog2(BEATS);

  typedef enum logic [1:0] {
    REFILL_IDLE = 2'd0,
    REFILL_REQ  = 2'd1,
    REFILL_RECV = 2'd2,
    REFILL_DONE = 2'd3
  } refill_state_e;

  typedef logic [WORD-1:0]                  word_t;
  typedef logic [CACHE_LINE_WIDTH-1:0]      line_t;
  typedef logic [CACHE_LINE_BYTE_LOG-3:0]   wsel_t;
  typedef logic [CNT_W-1:0]                 beat_cnt_t;

  function automatic logic is_last_beat(input beat_cnt_t cnt);
    return cnt == beat_cnt_t'(BEATS - 1);
  endfunction

endpackage

// File: rtl/icache_refill_unit_if.sv
// Miss request, memory read/return and line-write signals of the refill engine.
// early_valid/early_inst exist only when REFILL_EARLY_FWD_EN is defined.
interface icache_refill_unit_if
  import icache_refill_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) ();

  logic                  miss_req;
  logic [ADDR_WIDTH-1:0] miss_addr;
  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_rdy;
  logic                  ret_valid;
  logic                  ret_last;
  word_t                 ret_data;
  logic                  line_we;
  line_t                 line_data;
  wsel_t                 word_sel;
  logic                  refill_busy;
  logic                  refill_done;
  logic                  proto_err;
`ifdef REFILL_EARLY_FWD_EN
  logic                  early_valid;
  word_t                 early_inst;
`endif

  modport master (
    input  miss_req, miss_addr, rd_rdy, ret_valid, ret_last, ret_data,
    output rd_req, rd_addr, line_we, line_data, word_sel,
           refill_busy, refill_done, proto_err
`ifdef REFILL_EARLY_FWD_EN
    , output early_valid, early_inst
`endif
  );

  modport slave (
    output miss_req, miss_addr, rd_rdy, ret_valid, ret_last, ret_data,
    input  rd_req, rd_addr, line_we, line_data, word_sel,
           refill_busy, refill_done, proto_err
`ifdef REFILL_EARLY_FWD_EN
    , input early_valid, early_inst
`endif
  );

endinterface

// File: rtl/icache_refill_unit_beat_collector.sv
// Beat counter and line assembly: each accepted beat lands in slot cnt, line_done flags slot 3.
// proto_err is sticky and set whenever ret_last disagrees with the beat count.
module refill_beat_collector
  import icache_refill_unit_pkg::*;
(
  input  logic      clk,
  input  logic      rstn,
  input  logic      clr_i,
  input  logic      beat_en_i,
  input  logic      ret_last_i,
  input  word_t     ret_data_i,
  output beat_cnt_t cnt_o,
  output logic      line_done_o,
  output line_t     line_data_o,
  output logic      proto_err_o
);

  beat_cnt_t        cnt_q, cnt_d;
  line_t            line_q, line_d;
  logic             err_q, err_d;
  logic [BEATS-1:0] slot_we;

  always_comb begin
    slot_we = '0;
    cnt_d   = cnt_q;
    line_d  = line_q;
    err_d   = err_q;
    if (beat_en_i) begin
      slot_we[cnt_q] = 1'b1;
    end
    if (clr_i) begin
      cnt_d = '0;
    end else if (beat_en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
    // Untouched slots keep the previous line until this refill overwrites them.
    for (int k = 0; k < BEATS; k++) begin
      if (slot_we[k]) begin
        line_d[k*WORD +: WORD] = ret_data_i;
      end
    end
    if (beat_en_i && (ret_last_i != is_last_beat(cnt_q))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q  <= '0;
      line_q <= '0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      line_q <= line_d;
      err_q  <= err_d;
    end
  end

  assign cnt_o       = cnt_q;
  assign line_done_o = beat_en_i && is_last_beat(cnt_q);
  assign line_data_o = line_q;
  assign proto_err_o = err_q;

endmodule

// File: rtl/icache_refill_unit.sv
// I-cache refill engine: one line-aligned 4-beat read per miss, line_we 6+ cycles after miss_req.
// rd_req held until rd_rdy; beats may gap freely. REFILL_EARLY_FWD_EN adds early_valid/early_inst.
module icache_refill_unit
  import icache_refill_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  icache_refill_unit_if.master bus
);

  refill_state_e         state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  wsel_t                 ws_q, ws_d;
  logic                  rd_req_q, rd_req_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  clr_cnt;
  logic                  beat_en;
  logic                  line_done;
  beat_cnt_t             beat_idx;
  line_t                 line_data;
  logic                  proto_err;
  logic                  unused_addr_lsb;

  assign beat_en         = (state_q == REFILL_RECV) && bus.ret_valid;
  assign unused_addr_lsb = ^bus.miss_addr[1:0];

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    ws_d    = ws_q;
    clr_cnt = 1'b0;
    case (state_q)
      REFILL_IDLE: begin
        if (bus.miss_req) begin
          state_d = REFILL_REQ;
          addr_d  = {bus.miss_addr[ADDR_WIDTH-1:CACHE_LINE_BYTE_LOG],
                     {CACHE_LINE_BYTE_LOG{1'b0}}};
          ws_d    = bus.miss_addr[CACHE_LINE_BYTE_LOG-1:2];
          clr_cnt = 1'b1;
        end
      end
      REFILL_REQ: begin
        if (bus.rd_rdy) begin
          state_d = REFILL_RECV;
        end
      end
      REFILL_RECV: begin
        if (line_done) begin
          state_d = REFILL_DONE;
        end
      end
      REFILL_DONE: state_d = REFILL_IDLE;
      default:     state_d = REFILL_IDLE;
    endcase
    // Outputs are decoded from the next state so they leave the flops aligned with it.
    rd_req_d = (state_d == REFILL_REQ);
    busy_d   = (state_d != REFILL_IDLE);
    done_d   = (state_d == REFILL_DONE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= REFILL_IDLE;
      addr_q   <= '0;
      ws_q     <= '0;
      rd_req_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      ws_q     <= ws_d;
      rd_req_q <= rd_req_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  refill_beat_collector u_collector (
    .clk         (clk),
    .rstn        (rstn),
    .clr_i       (clr_cnt),
    .beat_en_i   (beat_en),
    .ret_last_i  (bus.ret_last),
    .ret_data_i  (bus.ret_data),
    .cnt_o       (beat_idx),
    .line_done_o (line_done),
    .line_data_o (line_data),
    .proto_err_o (proto_err)
  );

  assign bus.rd_req      = rd_req_q;
  assign bus.rd_addr     = addr_q;
  assign bus.word_sel    = ws_q;
  assign bus.refill_busy = busy_q;
  assign bus.line_we     = done_q;
  assign bus.refill_done = done_q;
  assign bus.line_data   = line_data;
  assign bus.proto_err   = proto_err;

`ifdef REFILL_EARLY_FWD_EN
  logic  early_vld_q, early_vld_d;
  word_t early_inst_q, early_inst_d;

  always_comb begin
    early_vld_d  = beat_en && (beat_idx == ws_q);
    early_inst_d = early_vld_d ? bus.ret_data : early_inst_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      early_vld_q  <= 1'b0;
      early_inst_q <= '0;
    end else begin
      early_vld_q  <= early_vld_d;
      early_inst_q <= early_inst_d;
    end
  end

  assign bus.early_valid = early_vld_q;
  assign bus.early_inst  = early_inst_q;
`else
  logic unused_beat_idx;
  assign unused_beat_idx = ^beat_idx;
`endif

endmodule

// File: tb/tb_icache_refill_unit.sv
// Directed + randomized refill sequences checked against a line/flag reference model.
module tb_icache_refill_unit;
  import icache_refill_unit_pkg::*;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  icache_refill_unit_if #(.ADDR_WIDTH(32)) bus ();

  icache_refill_unit #(.ADDR_WIDTH(32)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [127:0] ref_line = '0;
  logic         ref_err  = 1'b0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.rd_rdy    = 1'b0;
    bus.ret_valid = 1'b0;
    bus.ret_last  = 1'b0;
    bus.ret_data  = '0;
  endtask

  task automatic start_miss(input logic [31:0] a);
    bus.miss_req  = 1'b1;
    bus.miss_addr = a;
    @(negedge clk);
  endtask

  // Entered at the first negedge where rd_req must be high; leaves the DUT idle
  // (or, with hold, back in the request phase of the next refill).
  task automatic serve(input logic [31:0] a, input int d, input int gap, input bit rnd,
                       input logic [3:0] lastmask, input bit hold);
    logic [31:0] data [4];
    int          gaps [4];
    logic [31:0] ea;
    logic [1:0]  ws;
    logic        stable;
    ea = a & 32'hFFFF_FFF0;
    ws = a[3:2];
    for (int k = 0; k < 4; k++) begin
      data[k] = rnd ? $urandom : (32'hA0 + k);
      gaps[k] = rnd ? $urandom_range(0, gap) : gap;
    end
    chk("rd_req_up", bus.rd_req, 1'b1);
    chk("rd_addr", bus.rd_addr, ea);
    chk("word_sel", bus.word_sel, ws);
    chk("busy_up", bus.refill_busy, 1'b1);
    stable = 1'b1;
    for (int i = 0; i < d; i++) begin
      bus.rd_rdy    = 1'b0;
      bus.ret_valid = 1'($urandom_range(0, 1));
      bus.ret_last  = 1'($urandom_range(0, 1));
      bus.ret_data  = $urandom;
      @(negedge clk);
      if (bus.rd_req !== 1'b1 || bus.rd_addr !== ea) stable = 1'b0;
    end
    bus.ret_valid = 1'b0;
    bus.ret_last  = 1'b0;
    bus.rd_rdy    = 1'b1;
    @(negedge clk);
    bus.rd_rdy = 1'b0;
    if (d > 0) chk("req_stable", stable, 1'b1);
    chk("rd_req_drop", bus.rd_req, 1'b0);
    chk("line_kept", bus.line_data, ref_line);
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < gaps[k]; g++) begin
        @(negedge clk);
`ifdef REFILL_EARLY_FWD_EN
        chk("early_gap", bus.early_valid, 1'b0);
`endif
      end
      if (k == 3) chk("line_we_early", bus.line_we, 1'b0);
      bus.ret_valid = 1'b1;
      bus.ret_data  = data[k];
      bus.ret_last  = lastmask[k];
      @(negedge clk);
      bus.ret_valid = 1'b0;
      bus.ret_last  = 1'b0;
      ref_line[k*32 +: 32] = data[k];
`ifdef REFILL_EARLY_FWD_EN
      chk("early_valid", bus.early_valid, (k == ws));
      if (k == ws) chk("early_inst", bus.early_inst, data[k]);
`endif
    end
    if (lastmask != 4'b1000) ref_err = 1'b1;
    chk("line_we", bus.line_we, 1'b1);
    chk("refill_done", bus.refill_done, 1'b1);
    chk("line_data", bus.line_data, ref_line);
    chk("proto_err", bus.proto_err, ref_err);
    if (!hold) bus.miss_req = 1'b0;
    @(negedge clk);
    chk("line_we_once", bus.line_we, 1'b0);
    chk("done_once", bus.refill_done, 1'b0);
    chk("busy_idle", bus.refill_busy, 1'b0);
    chk("rd_req_idle", bus.rd_req, 1'b0);
    if (hold) begin
      @(negedge clk);
      chk("rearm", bus.rd_req, 1'b1);
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [3:0]  lm;
    bus.miss_req  = 1'b0;
    bus.miss_addr = '0;
    idle_inputs();
    @(negedge clk);
    chk("rst_rd_req", bus.rd_req, 1'b0);
    chk("rst_busy", bus.refill_busy, 1'b0);
    chk("rst_line", bus.line_data, '0);
    rstn = 1'b1;
    @(negedge clk);

    // Stray return beat while idle must be ignored.
    bus.ret_valid = 1'b1;
    bus.ret_last  = 1'b1;
    bus.ret_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    idle_inputs();
    chk("stray_line", bus.line_data, '0);
    chk("stray_err", bus.proto_err, 1'b0);
    chk("stray_busy", bus.refill_busy, 1'b0);

    // Back-to-back minimum-latency refill.
    start_miss(32'h1C00_0034);
    chk("t1_rd_addr", bus.rd_addr, 32'h1C00_0030);
    chk("t1_word_sel", bus.word_sel, 2'b01);
    serve(32'h1C00_0034, 0, 0, 1'b0, 4'b1000, 1'b0);
    chk("t1_line", bus.line_data, 128'h000000A3_000000A2_000000A1_000000A0);

    // Delayed grant and gapped beats.
    start_miss(32'h1C00_0034);
    serve(32'h1C00_0034, 5, 2, 1'b0, 4'b1000, 1'b0);
    chk("t2_line", bus.line_data, 128'h000000A3_000000A2_000000A1_000000A0);

    // Early ret_last: sticky error, line still completes on the fourth beat.
    a = $urandom;
    start_miss(a);
    serve(a, 1, 1, 1'b1, 4'b0100, 1'b0);
    a = $urandom;
    start_miss(a);
    serve(a, 0, 1, 1'b1, 4'b1000, 1'b0);
    chk("err_sticky", bus.proto_err, 1'b1);

    // miss_req held across DONE: one refill, then the next one re-arms.
    a = $urandom;
    start_miss(a);
    serve(a, 0, 0, 1'b1, 4'b1000, 1'b1);
    serve(a, 2, 1, 1'b1, 4'b1000, 1'b0);

    // Word-select 2 exercises the forwarded-instruction path.
    start_miss(32'h4000_1238);
    serve(32'h4000_1238, 0, 1, 1'b1, 4'b1000, 1'b0);

    for (int n = 0; n < 20; n++) begin
      a  = $urandom;
      lm = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b1000;
      start_miss(a);
      serve(a, $urandom_range(0, 3), 2, 1'b1, lm, 1'b0);
    end

    // Asynchronous reset in the middle of a refill.
    a = $urandom;
    start_miss(a);
    bus.rd_rdy = 1'b1;
    @(negedge clk);
    bus.rd_rdy = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus.ret_valid = 1'b1;
      bus.ret_data  = $urandom;
      @(negedge clk);
    end
    idle_inputs();
    #2 rstn = 1'b0;
    #1;
    chk("arst_rd_req", bus.rd_req, 1'b0);
    chk("arst_rd_addr", bus.rd_addr, '0);
    chk("arst_word_sel", bus.word_sel, '0);
    chk("arst_busy", bus.refill_busy, 1'b0);
    chk("arst_line_we", bus.line_we, 1'b0);
    chk("arst_done", bus.refill_done, 1'b0);
    chk("arst_err", bus.proto_err, 1'b0);
    chk("arst_line", bus.line_data, '0);
`ifdef REFILL_EARLY_FWD_EN
    chk("arst_early", bus.early_valid, 1'b0);
`endif
    ref_line = '0;
    ref_err  = 1'b0;
    bus.miss_req = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    start_miss(32'h0000_0100);
    serve(32'h0000_0100, 0, 0, 1'b1, 4'b1000, 1'b0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
